// File: rtl/count_event_monitor.sv
// count_event_monitor: classifies each change of an observed free-running counter
// as hold, step, wrap, restart or fault and keeps saturating statistics.
module count_event_monitor #(
   parameter int CNT_W  = 4,
   parameter int STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  count,
   input  logic              clr,
   output logic              wrap_pulse,
   output logic              restart_pulse,
   output logic [STAT_W-1:0] wraps,
   output logic [STAT_W-1:0] restarts,
   output logic              fault,
   output logic [CNT_W-1:0]  fault_prev,
   output logic [CNT_W-1:0]  fault_val,
   output logic [1:0]        state
);
   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FLT = 2'd2} state_t;
   localparam logic [CNT_W-1:0] TOP = '1;
   state_t st;
   logic [CNT_W-1:0] prev;
   logic is_hold, is_step, is_wrap, is_restart;
   assign state      = st;
   assign is_hold    = count == prev;
   assign is_step    = count == CNT_W'(prev + 1'b1) && prev != TOP;
   assign is_wrap    = prev == TOP && count == '0;
   assign is_restart = count == '0 && prev != '0 && prev != TOP;
   always_ff @(posedge clk) begin
      if (!rst) begin
         st            <= IDLE;
         prev          <= '0;
         wrap_pulse    <= 1'b0;
         restart_pulse <= 1'b0;
         wraps         <= '0;
         restarts      <= '0;
         fault         <= 1'b0;
         fault_prev    <= '0;
         fault_val     <= '0;
      end else if (clr) begin
         st            <= IDLE;
         prev          <= count;
         wrap_pulse    <= 1'b0;
         restart_pulse <= 1'b0;
         wraps         <= '0;
         restarts      <= '0;
         fault         <= 1'b0;
         fault_prev    <= '0;
         fault_val     <= '0;
      end else begin
         prev          <= count;
         wrap_pulse    <= 1'b0;
         restart_pulse <= 1'b0;
         if (st == IDLE) st <= TRACK;
         else if (st == TRACK) begin
            if (is_wrap) begin
               wrap_pulse <= 1'b1;
               if (wraps != '1) wraps <= wraps + 1'b1;
            end else if (is_restart) begin
               restart_pulse <= 1'b1;
               if (restarts != '1) restarts <= restarts + 1'b1;
            end else if (!is_hold && !is_step) begin
               // first illegal transition is latched; FAULT freezes everything but prev
               fault      <= 1'b1;
               fault_prev <= prev;
               fault_val  <= count;
               st         <= FLT;
            end
         end
      end
   end
endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream observer for the 4-bit free-running counter. It samples the counter's `count` output every clock and classifies each change as a normal step, a wrap (15→0), a restart (a return to 0 from a non-terminal value, caused by a counter reset), or a fault (any other jump). It produces one-cycle event pulses, saturating statistics, and a sticky fault flag with the offending values captured. It sits on the same clock as the counter and is the counter's health/statistics stage for the rest of the design.

## Interface
- `CNT_W`, 4: width of the observed count.
- `STAT_W`, 8: width of the `wraps` and `restarts` statistics counters.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `count`  in  CNT_W  counter value under observation, sampled at every rising edge.
- `clr`  in  1  synchronous clear of statistics and fault; re-arms the monitor.
- `wrap_pulse`  out  1  high for one cycle per detected wrap.
- `restart_pulse`  out  1  high for one cycle per detected restart.
- `wraps`  out  STAT_W  saturating wrap count.
- `restarts`  out  STAT_W  saturating restart count.
- `fault`  out  1  sticky; set on the first illegal transition.
- `fault_prev`  out  CNT_W  sample preceding the illegal transition.
- `fault_val`  out  CNT_W  illegal sample.
- `state`  out  2  FSM state: 0 = IDLE, 1 = TRACK, 2 = FAULT.

## Operation
- **Registers:** `prev` (CNT_W), state, statistics, fault capture, and registered pulses.
- **Reset** (`rst` = 0 at an edge):
  - state = IDLE, `prev` = 0.
  - All outputs are 0.
- **Priority at an edge:** `rst` > `clr` > event classification.
- **`clr` = 1:**
  - `wraps`, `restarts`, `fault`, `fault_prev`, `fault_val` and both pulses go to 0.
  - state goes to IDLE.
  - `prev` is loaded with `count`.
- **IDLE:** load `prev` = `count`, go to TRACK, no classification. The first sample after reset or clear never raises an event.
- **TRACK:** compare `cur` = `count` against `prev`, then set `prev` = `cur`.
  - hold: `cur` == `prev`. No event.
  - step: `cur` == `prev`+1 and `prev` != 2^CNT_W−1. No event.
  - wrap: `prev` == 2^CNT_W−1 and `cur` == 0. Set `wrap_pulse`; increment `wraps` unless it is at 2^STAT_W−1.
  - restart: `cur` == 0 and `prev` is neither 0 nor 2^CNT_W−1. Set `restart_pulse`; increment `restarts` with saturation.
  - anything else is a fault:
    - set `fault` = 1;
    - capture `fault_prev` = `prev` and `fault_val` = `cur`;
    - go to FAULT.
- **FAULT:**
  - No classification, no pulses; statistics are frozen.
  - `prev` keeps tracking `count`.
  - Leaves FAULT only on `clr` (to IDLE) or `rst`.
- **Arithmetic:** `prev`+1 is computed modulo 2^CNT_W for comparison only. A wrap is never classified as a step. Statistics saturate and never roll over.
- **Pulses:** `wrap_pulse` and `restart_pulse` are mutually exclusive and never asserted in IDLE or FAULT.

## Timing
- **Pulse latency:** if an edge k samples a transition, the pulse is high for exactly the cycle between edges k and k+1.
- **Statistics and fault latency:** `wraps`/`restarts` update and `fault`/capture registers take their values at the same edge k.
- **Counter stepping every cycle:** the counter updates on the same edge, so each counter value is seen exactly once.
- **Counter reset:** a counter reset held for several cycles shows as one restart followed by holds at 0.
- **Monitor reset mid-operation:** takes effect at the next edge. The following edge is an IDLE load, so no event is raised until the edge after that.
- **`clr` and an event on the same edge:** `clr` wins. The event is discarded and `prev` still loads `count`.

## Test plan
- **Free run through 40 counter cycles:**
  - release `rst`, count 0..15 repeatedly;
  - expect `wraps` = 2, `restarts` = 0, `fault` = 0;
  - expect `wrap_pulse` high exactly once per 15→0, one cycle after the sampling edge.
- **Counter reset mid-count:** count 5→6→0 (held 0 for 3 cycles) →1 → expect `restart_pulse` once, `restarts` = 1, no fault.
- **Illegal jump:**
  - inject count 3→9;
  - expect `fault` = 1, `fault_prev` = 3, `fault_val` = 9, state = 2;
  - a subsequent 15→0 produces no `wrap_pulse` and `wraps` stays unchanged.
- **Clear recovery:** from the fault above, pulse `clr` for one cycle → all statistics and `fault` = 0, state = IDLE then TRACK; a normal 15→0 then sets `wraps` = 1.
- **Saturation:** with STAT_W = 2, drive 5 wraps → `wraps` sticks at 3 and `wrap_pulse` still fires 5 times.
- **Reset and clear priority:**
  - `rst` = 0 on the same edge as a 15→0 wrap → no pulse, all outputs 0;
  - `clr` = 1 on a wrap edge → `wraps` = 0, no pulse.
